// File: rtl/bus_trace_buffer_if.sv
// bus_trace_buffer_if: CPU bus strobes/address/data plus the FIFO drain handshake.
// Ports (signals): iAddr, iDataR, iDataW, iMemW, iMemR, iIOW, iIOR (bus side, into the tracer);
// iPop (drain request, into the tracer); oValid, oEntry (head entry, out of the tracer).
// Modports: master = bus/drain driver, slave = the trace buffer.
// ENTRY_W widens by a 16-bit timestamp when TRACE_TIMESTAMP_EN is defined.
interface bus_trace_buffer_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
);
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 16 + 2 + ADDR_W + DATA_W;
`else
  localparam int ENTRY_W = 2 + ADDR_W + DATA_W;
`endif
  logic [ADDR_W-1:0] iAddr;
  logic [DATA_W-1:0] iDataR;
  logic [DATA_W-1:0] iDataW;
  logic iMemW, iMemR, iIOW, iIOR;
  logic iPop;
  logic oValid;
  logic [ENTRY_W-1:0] oEntry;
  modport master (output iAddr, iDataR, iDataW, iMemW, iMemR, iIOW, iIOR, iPop, input oValid, oEntry);
  modport slave (input iAddr, iDataR, iDataW, iMemW, iMemR, iIOW, iIOR, iPop, output oValid, oEntry);
endinterface

// File: rtl/bus_trace_buffer.sv
// bus_trace_buffer: captures one {type, addr, data} entry per completed 8088 bus cycle into a show-ahead FIFO.
// Ports: iClk, iRst (sync, active-high); bus (bus_trace_buffer_if.slave: strobes, addr, data, iPop, oValid, oEntry);
// iMask {MemW,MemR,IOW,IOR} capture enables; iFreeze; iClear; oLevel entry count; oDropCnt lost events.
// Macro TRACE_TIMESTAMP_EN prefixes each entry with a free-running 16-bit cycle counter.
module bus_trace_buffer #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter int DROP_W = 16
) (
  input  logic iClk,
  input  logic iRst,
  bus_trace_buffer_if.slave bus,
  input  logic [3:0] iMask,
  input  logic iFreeze,
  input  logic iClear,
  output logic [DEPTH_LOG2:0] oLevel,
  output logic [DROP_W-1:0] oDropCnt
);
  localparam int PAY_W = 2 + ADDR_W + DATA_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 16 + PAY_W;
`else
  localparam int ENTRY_W = PAY_W;
`endif
  logic [3:0] strb, prev, arm, ev;
  logic [ADDR_W-1:0] pAddr;
  logic [DATA_W-1:0] pDataR, pDataW;
  logic [DEPTH_LOG2:0] wp, rp;
  logic [ENTRY_W-1:0] mem [2**DEPTH_LOG2];
  logic [ENTRY_W-1:0] entry;
  logic [PAY_W-1:0] payload;
  logic [1:0] typ;
  logic [2:0] nEv, inc;
  logic [DROP_W:0] sum;
  logic full, empty, push, doPush, doPop;
  assign strb = {bus.iMemW, bus.iMemR, bus.iIOW, bus.iIOR};
  // arm only sets once a strobe has been seen low, so a strobe held high through reset needs a fresh rise
  always_ff @(posedge iClk) begin
    if (iRst) begin
      prev <= '0;
      arm <= '0;
      pAddr <= '0;
      pDataR <= '0;
      pDataW <= '0;
    end else begin
      prev <= strb;
      arm <= arm | ~strb;
      pAddr <= bus.iAddr;
      pDataR <= bus.iDataR;
      pDataW <= bus.iDataW;
    end
  end
  assign ev = prev & ~strb & arm & iMask & {4{~iFreeze}};
  assign typ = ev[0] ? 2'd3 : ev[1] ? 2'd2 : ev[2] ? 2'd1 : 2'd0;
  assign nEv = 3'(ev[0]) + 3'(ev[1]) + 3'(ev[2]) + 3'(ev[3]);
  assign payload = {typ, pAddr, typ[0] ? pDataR : pDataW};
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts;
  always_ff @(posedge iClk) ts <= iRst ? 16'd0 : ts + 16'd1;
  assign entry = {ts, payload};
`else
  assign entry = payload;
`endif
  assign empty = wp == rp;
  assign full = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) && (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
  assign push = |ev;
  assign doPop = bus.iPop & ~empty;
  // a full FIFO still accepts the push when the head is popped on the same edge
  assign doPush = push & (~full | doPop);
  // losers of the priority pick plus a rejected winner: nEv-1 + !doPush
  assign inc = push ? nEv - 3'(doPush) : 3'd0;
  assign sum = {1'b0, oDropCnt} + (DROP_W+1)'(inc);
  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      wp <= '0;
      rp <= '0;
      oDropCnt <= '0;
    end else begin
      if (doPush) wp <= wp + 1'b1;
      if (doPop) rp <= rp + 1'b1;
      oDropCnt <= sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    end
  end
  always_ff @(posedge iClk) if (!iRst && !iClear && doPush) mem[wp[DEPTH_LOG2-1:0]] <= entry;
  assign oLevel = wp - rp;
  assign bus.oValid = ~empty;
  assign bus.oEntry = empty ? '0 : mem[rp[DEPTH_LOG2-1:0]];
endmodule

// File: tb/tb_bus_trace_buffer.sv
// tb_bus_trace_buffer: directed self-checking bench for bus_trace_buffer with a 4-entry FIFO.
module tb_bus_trace_buffer;
  localparam int PAY_W = 30;
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 16 + PAY_W;
`else
  localparam int ENTRY_W = PAY_W;
`endif
  logic iClk = 0, iRst = 1, iFreeze = 0, iClear = 0;
  logic [3:0] iMask = 4'hF;
  logic [2:0] oLevel;
  logic [15:0] oDropCnt;
  int nVec = 0, nErr = 0;
  bus_trace_buffer_if #(.ADDR_W(20), .DATA_W(8)) bus ();
  bus_trace_buffer #(.ADDR_W(20), .DATA_W(8), .DEPTH_LOG2(2), .DROP_W(16)) dut (
    .iClk(iClk), .iRst(iRst), .bus(bus.slave), .iMask(iMask), .iFreeze(iFreeze),
    .iClear(iClear), .oLevel(oLevel), .oDropCnt(oDropCnt)
  );
  always #5 iClk = ~iClk;
  task automatic cyc();
    @(negedge iClk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic setStb(input logic [3:0] s);
    {bus.iMemW, bus.iMemR, bus.iIOW, bus.iIOR} = s;
  endtask
  task automatic pulse(input logic [3:0] s, input logic [19:0] a, input logic [7:0] dr, input logic [7:0] dw);
    bus.iAddr = a;
    bus.iDataR = dr;
    bus.iDataW = dw;
    setStb(s);
    cyc();
    setStb(4'b0000);
    cyc();
  endtask
  task automatic pop();
    bus.iPop = 1;
    cyc();
    bus.iPop = 0;
  endtask
  task automatic clr();
    iClear = 1;
    cyc();
    iClear = 0;
  endtask
  logic [15:0] t0, n16;
  initial begin
    setStb(4'b0000);
    bus.iAddr = '0;
    bus.iDataR = '0;
    bus.iDataW = '0;
    bus.iPop = 0;
    repeat (3) cyc();
    iRst = 0;
    cyc();
    chk("rst_valid", 64'(bus.oValid), 64'd0);
    chk("rst_entry", 64'(bus.oEntry), 64'd0);
    chk("rst_level", 64'(oLevel), 64'd0);
    chk("rst_drop", 64'(oDropCnt), 64'd0);
    // IOW pulse, 3 cycles high
    bus.iAddr = 20'h003D4;
    bus.iDataW = 8'h0E;
    setStb(4'b0010);
    repeat (3) cyc();
    setStb(4'b0000);
    chk("iow_valid_before", 64'(bus.oValid), 64'd0);
    cyc();
    chk("iow_valid", 64'(bus.oValid), 64'd1);
    chk("iow_entry", 64'(bus.oEntry[PAY_W-1:0]), 64'({2'd2, 20'h003D4, 8'h0E}));
    chk("iow_level", 64'(oLevel), 64'd1);
    pop();
    chk("iow_pop_valid", 64'(bus.oValid), 64'd0);
    // MemR with read data changing on the falling cycle
    bus.iAddr = 20'hFE123;
    bus.iDataR = 8'hAA;
    setStb(4'b0100);
    repeat (2) cyc();
    setStb(4'b0000);
    bus.iDataR = 8'h55;
    cyc();
    chk("memr_entry", 64'(bus.oEntry[PAY_W-1:0]), 64'({2'd1, 20'hFE123, 8'hAA}));
    pop();
    // IOR and MemW fall together
    pulse(4'b1001, 20'h12345, 8'h33, 8'h44);
    chk("simul_entry", 64'(bus.oEntry[PAY_W-1:0]), 64'({2'd3, 20'h12345, 8'h33}));
    chk("simul_level", 64'(oLevel), 64'd1);
    chk("simul_drop", 64'(oDropCnt), 64'd1);
    pop();
    clr();
    chk("clr_drop", 64'(oDropCnt), 64'd0);
    // overflow a 4-deep FIFO
    for (int i = 0; i < 6; i++) pulse(4'b0010, 20'h00100, 8'h00, 8'(i));
    chk("ovf_level", 64'(oLevel), 64'd4);
    chk("ovf_drop", 64'(oDropCnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 64'(bus.oEntry[7:0]), 64'(i));
      pop();
    end
    chk("drain_valid", 64'(bus.oValid), 64'd0);
    pop();
    chk("empty_pop_level", 64'(oLevel), 64'd0);
    chk("empty_pop_drop", 64'(oDropCnt), 64'd2);
    // full FIFO, push and pop on the same edge
    clr();
    for (int i = 0; i < 4; i++) pulse(4'b0010, 20'h00200, 8'h00, 8'(8'h10 + i));
    bus.iDataW = 8'h14;
    setStb(4'b0010);
    cyc();
    setStb(4'b0000);
    bus.iPop = 1;
    cyc();
    bus.iPop = 0;
    chk("fullpp_level", 64'(oLevel), 64'd4);
    chk("fullpp_drop", 64'(oDropCnt), 64'd0);
    chk("fullpp_head", 64'(bus.oEntry[7:0]), 64'h11);
    pop();
    chk("fullpp_h2", 64'(bus.oEntry[7:0]), 64'h12);
    pop();
    chk("fullpp_h3", 64'(bus.oEntry[7:0]), 64'h13);
    pop();
    chk("fullpp_last", 64'(bus.oEntry[7:0]), 64'h14);
    // clear coincident with an event
    setStb(4'b0010);
    cyc();
    setStb(4'b0000);
    iClear = 1;
    cyc();
    iClear = 0;
    chk("clrev_level", 64'(oLevel), 64'd0);
    chk("clrev_drop", 64'(oDropCnt), 64'd0);
    cyc();
    chk("clrev_valid", 64'(bus.oValid), 64'd0);
    // mask IOR only, with freeze
    iMask = 4'b0001;
    pulse(4'b1000, 20'h00300, 8'h01, 8'h02);
    pulse(4'b0010, 20'h00301, 8'h03, 8'h04);
    chk("mask_level", 64'(oLevel), 64'd0);
    chk("mask_drop", 64'(oDropCnt), 64'd0);
    pulse(4'b0001, 20'h00302, 8'h05, 8'h06);
    chk("mask_ior", 64'(bus.oEntry[PAY_W-1:0]), 64'({2'd3, 20'h00302, 8'h05}));
    iFreeze = 1;
    pulse(4'b0001, 20'h00303, 8'h07, 8'h08);
    iFreeze = 0;
    chk("freeze_level", 64'(oLevel), 64'd1);
    chk("freeze_drop", 64'(oDropCnt), 64'd0);
    pop();
    iMask = 4'hF;
    // reset with a strobe held high
    pulse(4'b0010, 20'h00400, 8'h00, 8'h09);
    setStb(4'b0010);
    iRst = 1;
    cyc();
    chk("rst_mid_level", 64'(oLevel), 64'd0);
    iRst = 0;
    repeat (2) cyc();
    setStb(4'b0000);
    cyc();
    chk("rst_held_level", 64'(oLevel), 64'd0);
    pulse(4'b0010, 20'h00401, 8'h00, 8'h0A);
    chk("rst_fresh_level", 64'(oLevel), 64'd1);
    pop();
`ifdef TRACE_TIMESTAMP_EN
    pulse(4'b0010, 20'h00500, 8'h00, 8'h0B);
    t0 = bus.oEntry[ENTRY_W-1 -: 16];
    pop();
    repeat (7) cyc();
    pulse(4'b0010, 20'h00501, 8'h00, 8'h0C);
    chk("ts_diff", 64'(bus.oEntry[ENTRY_W-1 -: 16]), 64'(16'(t0 + 16'd10)));
    t0 = bus.oEntry[ENTRY_W-1 -: 16];
    pop();
    n16 = 16'hFFF9 - t0;
    repeat (int'(n16)) cyc();
    pulse(4'b0010, 20'h00502, 8'h00, 8'h0D);
    chk("ts_prewrap", 64'(bus.oEntry[ENTRY_W-1 -: 16]), 64'hFFFC);
    pop();
    repeat (7) cyc();
    pulse(4'b0010, 20'h00503, 8'h00, 8'h0E);
    chk("ts_wrap", 64'(bus.oEntry[ENTRY_W-1 -: 16]), 64'h0006);
    pop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/bus_trace_buffer.md
# bus_trace_buffer

Parametrised bus-cycle capture buffer for the 8088 system: a successor to the simulation-only tracer that turns the `$display` logging into synthesizable hardware. It watches the decoded CPU strobes (MemW, MemR, IOW, IOR) and records one entry per completed bus cycle into a show-ahead FIFO. Each entry holds the cycle type, address and data. Capture is per-type maskable, freezable and clearable. Lost events are counted, and the FIFO is drained through a valid/pop port by a debug UART or the testbench.

## Interface
Parameters:
- ADDR_W, 20, width of captured address
- DATA_W, 8, width of captured data
- DEPTH_LOG2, 6, FIFO depth = 2**DEPTH_LOG2 entries
- DROP_W, 16, width of the drop counter

Ports:
- iClk  in  1  system clock
- iRst  in  1  reset, synchronous, active-high
- iAddr  in  ADDR_W  latched CPU address
- iDataR  in  DATA_W  CPU read data
- iDataW  in  DATA_W  CPU write data
- iMemW, iMemR, iIOW, iIOR  in  1 each  active-high bus strobes
- iMask  in  4  per-type capture enable {MemW, MemR, IOW, IOR}; 1 = capture
- iFreeze  in  1  1 = ignore all events; the FIFO contents are kept
- iClear  in  1  flush the FIFO and zero oDropCnt
- iPop  in  1  consume the head entry
- oValid  out  1  FIFO non-empty
- oEntry  out  ENTRY_W  head entry, {type[1:0], addr, data}, plus timestamp when enabled
- oLevel  out  DEPTH_LOG2+1  number of stored entries
- oDropCnt  out  DROP_W  number of events lost

## Operation
- Strobes, address and data are registered every cycle; the registered copy is the "previous" sample.
- **Event definition:** a strobe is 1 in the previous sample and 0 at the current input (falling edge). The event is qualified by its iMask bit and by !iFreeze.
- **Captured fields:** address and data come from the previous sample, i.e. the last cycle the strobe was high.
  - Data is iDataW for MemW/IOW and iDataR for MemR/IOR.
- **Type codes:** 0 = MemW, 1 = MemR, 2 = IOW, 3 = IOR.
- **Simultaneous events:** at most one push per cycle. Priority is IOR > IOW > MemR > MemW. Each losing qualified event increments oDropCnt.
- **FIFO full:** the push is rejected and oDropCnt increments by 1.
- **Push and pop in the same cycle:**
  - When full, both occur; the level is unchanged.
  - When empty, the push occurs and the pop is ignored.
- iPop while !oValid has no effect.
- oDropCnt saturates at all-ones. Increments within one cycle are summed, with a maximum of 4.
- **iClear:**
  - Empties the FIFO and zeroes oDropCnt.
  - Takes priority over a push or pop in the same cycle; an event in that cycle is discarded and not counted.
  - The previous-sample registers keep updating.
- Pointers are DEPTH_LOG2+1 bits; they wrap naturally and full/empty is decided by the MSB compare.

## Timing
- Reset values: oValid = 0, oEntry = 0, oLevel = 0, oDropCnt = 0. Previous-sample registers = 0, so a strobe already high at reset release produces no false event. The timestamp counter = 0.
- **Latency:** strobe low is first seen at posedge k → the entry is written at posedge k → oValid = 1 and oEntry is valid after posedge k. The entry is visible 1 cycle after the strobe drops.
- oEntry is show-ahead: it is combinational from the head pointer and changes after the posedge on which iPop is accepted.
- oLevel and oDropCnt are registered and update on the same edge as the push or pop.
- iRst mid-capture discards all entries. The first event after release requires a fresh rising edge, then a falling edge.

## Configuration
- Macro: TRACE_TIMESTAMP_EN.
- **Defined:**
  - A free-running 16-bit counter increments every iClk and wraps at 0xFFFF → 0x0000.
  - Each entry is prefixed with the counter value at the push edge.
  - ENTRY_W = 16+2+ADDR_W+DATA_W.
- **Undefined:** no counter is built and ENTRY_W = 2+ADDR_W+DATA_W. Behaviour is otherwise identical.

## Test plan
- IOW pulse, iAddr = 0x003D4, iDataW = 0x0E, 3 cycles high → one entry {2, 0x003D4, 0x0E}; oValid rises 1 cycle after the strobe falls; oLevel = 1.
- MemR pulse with iAddr = 0xFE123 held and iDataR changing to 0x55 in the cycle the strobe falls (0xAA before) → entry {1, 0xFE123, 0xAA}.
- IOR and MemW fall in the same cycle → one entry of type 3; oDropCnt = 1.
- DEPTH_LOG2 = 2: 6 IOW events with no pops → oLevel = 4, oDropCnt = 2. Then pop 4 times → entries in order, then oValid = 0. iPop while empty → no change.
- Full FIFO with push and pop in the same cycle → oLevel stays 4 and the new entry appears last. iClear coincident with an event → oLevel = 0, oDropCnt = 0.
- iMask = 4'b0001 (IOR only) with iFreeze toggled: MemW and IOW ignored; IOR captured only while iFreeze = 0. With TRACE_TIMESTAMP_EN: two events 10 cycles apart → timestamps differ by 10, including across the 0xFFFF wrap.
